// File: rtl/nibble_serial_addsub_seq.sv
// nibble_serial_addsub_seq: W-bit add/subtract computed one nibble per clock on a shared 4-bit slice
module nibble_serial_addsub_seq #(
    parameter int NIBBLES = 4,
    localparam int W = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic         op_sub_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] result_o,
    output logic         carry_out_o,
    output logic         overflow_o
);
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, result_q, result_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          sub_q, sub_d, carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [3:0]    an, bn, low;
    logic [4:0]    sum;
    logic          accept;

    // Shared slice: current nibble of A plus (optionally inverted) nibble of B plus held carry
    always_comb begin
        an  = a_q[4*idx_q +: 4];
        bn  = b_q[4*idx_q +: 4] ^ {4{sub_q}};
        sum = {1'b0, an} + {1'b0, bn} + {4'b0, carry_q};
        low = {1'b0, an[2:0]} + {1'b0, bn[2:0]} + {3'b0, carry_q};
    end

    assign accept = start_i && (state_q == IDLE || state_q == DONE);

    // Next state: capture on accepted start, one nibble per RUN cycle, flags on the last nibble
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        if (accept) begin
            state_d  = RUN;
            a_d      = a_i;
            b_d      = b_i;
            sub_d    = op_sub_i;
            idx_d    = '0;
            carry_d  = op_sub_i;
            result_d = '0;
            cout_d   = 1'b0;
            ovf_d    = 1'b0;
        end else if (state_q == RUN) begin
            result_d[4*idx_q +: 4] = sum[3:0];
            carry_d = sum[4];
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST) begin
                state_d = DONE;
                cout_d  = sum[4];
                ovf_d   = sum[4] ^ low[3];
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    // State registers with synchronous reset that aborts any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy_o      = (state_q == RUN);
    assign done_o      = (state_q == DONE);
    assign result_o    = result_q;
    assign carry_out_o = cout_q;
    assign overflow_o  = ovf_q;
endmodule

// File: tb/tb_nibble_serial_addsub_seq.sv
// tb_nibble_serial_addsub_seq: scoreboard bench for the nibble-serial add/subtract sequencer
module tb_nibble_serial_addsub_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        op_sub_i = 1'b0;
    logic [15:0] a_i = '0;
    logic [15:0] b_i = '0;
    logic        busy_o, done_o, carry_out_o, overflow_o;
    logic [15:0] result_o;

    typedef struct {
        int          id;
        logic [15:0] r;
        logic        c;
        logic        o;
        int          t;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   next_id = 0;

    nibble_serial_addsub_seq #(.NIBBLES(4)) dut (
        .clk(clk),
        .rst(rst),
        .start_i(start_i),
        .op_sub_i(op_sub_i),
        .a_i(a_i),
        .b_i(b_i),
        .busy_o(busy_o),
        .done_o(done_o),
        .result_o(result_o),
        .carry_out_o(carry_out_o),
        .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done pulse must match the oldest outstanding expectation, at the expected cycle
    always @(negedge clk) begin
        if (!rst && done_o) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done cyc=%0d result=%h", cyc, result_o);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (result_o !== e.r || carry_out_o !== e.c || overflow_o !== e.o || cyc != e.t || busy_o !== 1'b0) begin
                    errors++;
                    $display("FAIL op%0d got result=%h carry=%b ovf=%b cyc=%0d busy=%b, want result=%h carry=%b ovf=%b cyc=%0d busy=0",
                             e.id, result_o, carry_out_o, overflow_o, cyc, busy_o, e.r, e.c, e.o, e.t);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [19:0] got, input logic [19:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic expect_op(input logic [15:0] r, input logic c, input logic o);
        q.push_back('{next_id, r, c, o, cyc + 5});
        next_id++;
    endtask

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [15:0] r, input logic c, input logic o);
        start_i  = 1'b1;
        a_i      = a;
        b_i      = b;
        op_sub_i = s;
        expect_op(r, c, o);
        @(negedge clk);
        start_i  = 1'b0;
        a_i      = 16'hDEAD;
        b_i      = 16'hBEEF;
        op_sub_i = ~s;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_outputs", {busy_o, done_o, result_o, carry_out_o, overflow_o}, 20'h0);
        rst = 1'b0;
        @(negedge clk);

        do_op(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        do_op(16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0);
        do_op(16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0);

        // start pulsed mid-RUN with other operands must be ignored
        start_i = 1'b1; a_i = 16'h0F0F; b_i = 16'h00F1; op_sub_i = 1'b0;
        expect_op(16'h1000, 1'b0, 1'b0);
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        chk("busy_in_run", {19'h0, busy_o}, 20'h1);
        start_i = 1'b1; a_i = 16'hFFFF; b_i = 16'hFFFF; op_sub_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);

        // start held high through DONE chains operations every 5 cycles
        start_i = 1'b1;
        a_i = 16'hAAAA; b_i = 16'h5555; op_sub_i = 1'b0;
        expect_op(16'hFFFF, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        a_i = 16'h1234; b_i = 16'h0234; op_sub_i = 1'b1;
        expect_op(16'h1000, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        a_i = 16'h8000; b_i = 16'h8000; op_sub_i = 1'b0;
        expect_op(16'h0000, 1'b1, 1'b1);
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(negedge clk);

        // reset mid-RUN aborts without a done pulse
        start_i = 1'b1; a_i = 16'hFFFF; b_i = 16'h0001; op_sub_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_run_reset", {busy_o, done_o, result_o, carry_out_o, overflow_o}, 20'h0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("idle_after_abort", {busy_o, done_o, result_o, carry_out_o, overflow_o}, 20'h0);
        do_op(16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1);

        // reset wins over a simultaneous start
        rst = 1'b1; start_i = 1'b1; a_i = 16'h1111; b_i = 16'h2222;
        @(negedge clk);
        chk("rst_beats_start", {busy_o, done_o, result_o, carry_out_o, overflow_o}, 20'h0);
        rst = 1'b0; start_i = 1'b0;
        @(negedge clk);
        chk("idle_after_rst_start", {18'h0, busy_o, done_o}, 20'h0);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
